// File: rtl/mult_button_driver_pkg.sv
// Shared types and constants for the multiplier button driver.
package mult_drv_pkg;

    localparam int DATA_W_DEF = 8;

    // The multiplier buttons are active-low.
    localparam logic BTN_ON  = 1'b0;
    localparam logic BTN_OFF = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOADB,
        SETA,
        RUN,
        WAIT,
        CAPT,
        RESP
    } mult_drv_state_t;

endpackage

// File: rtl/mult_button_driver_phase_timer.sv
// Loadable down-counter; done is high while the count is zero. It holds at zero.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mult_button_driver.sv
// Drives the shift-add multiplier's buttons/switches for one operand pair and returns the product.
// Optional self-check of the captured product: define MULT_BUTTON_DRIVER_CHECK_EN.
module mult_button_driver
    import mult_drv_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PULSE_CYC = 2,
    parameter int MULT_LAT  = 20
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_prod,
    output logic                busy,
    output logic [DATA_W-1:0]   S,
    output logic                ClearA_LoadB,
    output logic                Run,
    input  logic [DATA_W-1:0]   Aval,
    input  logic [DATA_W-1:0]   Bval
`ifdef MULT_BUTTON_DRIVER_CHECK_EN
    ,
    output logic                err,
    output logic [7:0]          err_cnt
`endif
);

    localparam logic [7:0] PULSE_M1 = 8'(PULSE_CYC - 1);
    localparam logic [7:0] LAT_M1   = 8'(MULT_LAT - 1);

    mult_drv_state_t     state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   s_q, s_d;
    logic                cl_q, cl_d;
    logic                run_q, run_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0] rsp_prod_q, rsp_prod_d;

    logic                tmr_load;
    logic [7:0]          tmr_val;
    logic                tmr_done;

    phase_timer #(
        .W (8)
    ) u_phase_timer (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

`ifdef MULT_BUTTON_DRIVER_CHECK_EN
    logic                       err_q, err_d;
    logic [7:0]                 err_cnt_q, err_cnt_d;
    logic signed [2*DATA_W-1:0] a_ext, b_ext, chk_prod;

    assign a_ext    = {{DATA_W{a_q[DATA_W-1]}}, a_q};
    assign b_ext    = {{DATA_W{b_q[DATA_W-1]}}, b_q};
    assign chk_prod = a_ext * b_ext;
`endif

    // Outputs are computed for the next state so every button/switch comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        cl_d        = cl_q;
        run_d       = run_q;
        rsp_valid_d = rsp_valid_q;
        rsp_prod_d  = rsp_prod_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d      = req_a;
                    b_d      = req_b;
                    s_d      = req_b;
                    cl_d     = BTN_ON;
                    state_d  = LOADB;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_M1;
                end
            end
            LOADB: begin
                if (tmr_done) begin
                    cl_d     = BTN_OFF;
                    s_d      = a_q;
                    state_d  = SETA;
                    tmr_load = 1'b1;
                end
            end
            SETA: begin
                run_d    = BTN_ON;
                state_d  = RUN;
                tmr_load = 1'b1;
                tmr_val  = PULSE_M1;
            end
            RUN: begin
                if (tmr_done) begin
                    run_d    = BTN_OFF;
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = LAT_M1;
                end
            end
            WAIT: begin
                if (tmr_done) begin
                    state_d  = CAPT;
                    tmr_load = 1'b1;
                end
            end
            CAPT: begin
                rsp_prod_d  = {Aval, Bval};
                rsp_valid_d = 1'b1;
                state_d     = RESP;
                tmr_load    = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    tmr_load    = 1'b1;
                end
            end
            default: begin
                cl_d        = BTN_OFF;
                run_d       = BTN_OFF;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

`ifdef MULT_BUTTON_DRIVER_CHECK_EN
    always_comb begin
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (state_q == CAPT && {Aval, Bval} != chk_prod) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cl_q        <= BTN_OFF;
            run_q       <= BTN_OFF;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_prod_q  <= '0;
`ifdef MULT_BUTTON_DRIVER_CHECK_EN
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            cl_q        <= cl_d;
            run_q       <= run_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_prod_q  <= rsp_prod_d;
`ifdef MULT_BUTTON_DRIVER_CHECK_EN
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_prod     = rsp_prod_q;
    assign S            = s_q;
    assign ClearA_LoadB = cl_q;
    assign Run          = run_q;
`ifdef MULT_BUTTON_DRIVER_CHECK_EN
    assign err          = err_q;
    assign err_cnt      = err_cnt_q;
`endif

endmodule

// File: tb/tb_mult_button_driver.sv
// Directed bench for mult_button_driver with a behavioural multiplier on the button interface.
module tb_mult_button_driver;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_prod;
    logic        busy;
    logic [7:0]  s_sw;
    logic        clra_ldb;
    logic        run_btn;
    logic [7:0]  aval;
    logic [7:0]  bval;

    int n_vec = 0;
    int n_err = 0;

    // Multiplier stand-in: B loads while ClearA_LoadB is low, A is taken from S while Run is low.
    logic [7:0]         mdl_a, mdl_b;
    logic signed [15:0] mdl_prod;
    bit                 force_bad = 1'b0;

    always @(posedge clk) begin
        if (!clra_ldb) mdl_b <= s_sw;
        if (!run_btn)  mdl_a <= s_sw;
    end
    assign mdl_prod = $signed({{8{mdl_a[7]}}, mdl_a}) * $signed({{8{mdl_b[7]}}, mdl_b});
    assign aval     = mdl_prod[15:8];
    assign bval     = force_bad ? 8'h02 : mdl_prod[7:0];

`ifdef MULT_BUTTON_DRIVER_CHECK_EN
    logic       err;
    logic [7:0] err_cnt;
    int         err_pulses = 0;
    always @(negedge clk) if (err) err_pulses++;
`endif

    mult_button_driver #(
        .DATA_W    (8),
        .PULSE_CYC (2),
        .MULT_LAT  (20)
    ) dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_prod     (rsp_prod),
        .busy         (busy),
        .S            (s_sw),
        .ClearA_LoadB (clra_ldb),
        .Run          (run_btn),
        .Aval         (aval),
        .Bval         (bval)
`ifdef MULT_BUTTON_DRIVER_CHECK_EN
        ,
        .err          (err),
        .err_cnt      (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: cycle n is the n-th negedge after the accept edge.
    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp, input bit scramble, input int hold);
        int n, cl, rn, ovl, bad_sb, bad_sa, bad_rdy, lat, hv;
        bit got;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        rsp_ready = (hold == 0);
        @(posedge clk);
        n = 0; cl = 0; rn = 0; ovl = 0; bad_sb = 0; bad_sa = 0; bad_rdy = 0; lat = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (scramble) begin
                req_a = 8'($urandom);
                req_b = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            if (!clra_ldb) begin
                cl++;
                if (s_sw != b) bad_sb++;
            end
            if (!run_btn) begin
                rn++;
                if (s_sw != a) bad_sa++;
            end
            if (!clra_ldb && !run_btn) ovl++;
            if (req_ready || !busy) bad_rdy++;
            if (rsp_valid) begin
                got = 1'b1;
                lat = n;
            end
        end
        req_valid = 1'b0;
        chk({tag, "_latency"}, lat, 27);
        chk({tag, "_loadb_cycles"}, cl, 2);
        chk({tag, "_run_cycles"}, rn, 2);
        chk({tag, "_btn_overlap"}, ovl, 0);
        chk({tag, "_s_during_loadb"}, bad_sb, 0);
        chk({tag, "_s_during_run"}, bad_sa, 0);
        chk({tag, "_busy_no_accept"}, bad_rdy, 0);
        chk({tag, "_prod"}, 32'(rsp_prod), 32'(exp));
        if (hold > 0) begin
            hv = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_prod != exp || req_ready) hv++;
            end
            chk({tag, "_hold_stable"}, hv, 0);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_run"}, 32'(run_btn), 32'd1);
        chk({tag, "_clra"}, 32'(clra_ldb), 32'd1);
        chk({tag, "_s"}, 32'(s_sw), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin : stim
        int n, stray;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_prod", 32'(rsp_prod), 32'd0);
        rst_n = 1'b1;

        run_txn("ff_ff", 8'hFF, 8'hFF, 16'h0001, 1'b0, 0);
        run_txn("scramble", 8'h07, 8'h03, 16'h0015, 1'b1, 0);
        run_txn("backpress", 8'h80, 8'h7F, 16'hC080, 1'b0, 10);
        run_txn("zero", 8'h5A, 8'h00, 16'h0000, 1'b0, 0);

        // Reset in the middle of the multiply wait.
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 8'h12;
        req_b     = 8'h34;
        rsp_ready = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        n     = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (rsp_valid || busy) stray++;
        end
        chk("midrst_no_response", stray, 0);
        run_txn("after_rst", 8'h12, 8'h34, 16'h03A8, 1'b0, 0);

`ifdef MULT_BUTTON_DRIVER_CHECK_EN
        begin
            int base;
            force_bad = 1'b1;
            base = err_pulses;
            run_txn("bad_mult", 8'hFF, 8'hFF, 16'h0002, 1'b0, 0);
            force_bad = 1'b0;
            chk("bad_err_pulses", err_pulses - base, 1);
            chk("bad_err_cnt", 32'(err_cnt), 32'd1);
            base = err_pulses;
            run_txn("good_mult", 8'h07, 8'h03, 16'h0015, 1'b0, 0);
            chk("good_err_pulses", err_pulses - base, 0);
            chk("good_err_cnt", 32'(err_cnt), 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_button_driver.md
Name: mult_button_driver

Overview:
- Hardware initiator for the 8-bit shift-add multiplier's button/switch interface (S, ClearA_LoadB, Run, Aval, Bval).
- Accepts an operand pair over a valid/ready request channel.
- Sequences the active-low button pulses with defined hold times, waits the fixed multiply latency, captures {Aval,Bval} and returns the 16-bit signed product over a valid/ready response channel.
- Sits between a host/self-test controller and the multiplier top level; replaces the manual stimulus sequence on the board.

Parameters:
- DATA_W, 8: operand width; product is 2*DATA_W.
- PULSE_CYC, 2: cycles each button is held asserted (low); legal range 1..15.
- MULT_LAT, 20: cycles from Run release until {Aval,Bval} is valid; legal range 1..255.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  operand pair valid.
- req_ready  out  1  block can accept a request.
- req_a  in  DATA_W  multiplicand (driven on S during Run).
- req_b  in  DATA_W  multiplier (loaded into register B).
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accepts product.
- rsp_prod  out  2*DATA_W  signed product {Aval,Bval}.
- busy  out  1  high in every state except IDLE.
- S  out  DATA_W  switch value to multiplier.
- ClearA_LoadB  out  1  active-low button.
- Run  out  1  active-low button.
- Aval  in  DATA_W  multiplier register A (upper product).
- Bval  in  DATA_W  multiplier register B (lower product).

Behaviour:
- Reset (async, Reset=0): state IDLE.
  - Outputs: ClearA_LoadB=1, Run=1, S=0, req_ready=1, rsp_valid=0, rsp_prod=0, busy=0.
  - All counters cleared.
- FSM states: IDLE, LOADB, SETA, RUN, WAIT, CAPT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_a and req_b and go to LOADB.
- LOADB: S=b, ClearA_LoadB=0 for exactly PULSE_CYC cycles, then go to SETA.
- SETA: ClearA_LoadB=1, S=a, for 1 cycle. This provides release and setup time. Then go to RUN.
- RUN: S=a, Run=0 for exactly PULSE_CYC cycles, then go to WAIT.
- WAIT: Run=1, S=a held, for exactly MULT_LAT cycles, then go to CAPT.
- CAPT: rsp_prod <= {Aval,Bval} registered, for 1 cycle, then go to RESP.
- RESP: rsp_valid=1 and rsp_prod stable until rsp_ready. The transfer cycle returns to IDLE.
- Latency: first rsp_valid cycle is 2*PULSE_CYC+MULT_LAT+3 cycles after the accept edge. Defaults give 27.
- Throughput: a new request is accepted only in IDLE; no pipelining. The earliest re-accept is 1 cycle after the response transfer.
- Button outputs are registered and glitch-free. Never ClearA_LoadB=0 and Run=0 in the same cycle.
- S changes only on state transitions.
- req_a/req_b changes after accept are ignored; the latched copies are used.
- rsp_ready held high before rsp_valid: no effect. rsp_valid never drops without a transfer.
- Reset asserted mid-sequence: immediate return to IDLE, buttons released, no response issued.
- Phase counter is 8 bits and shared across phases. It reloads on every state entry and never wraps.

Optional Feature:
- Macro: MULT_BUTTON_DRIVER_CHECK_EN.
- Defined:
  - Adds output err (1) and err_cnt (8).
  - In CAPT, computes signed req_a*req_b internally and compares it with {Aval,Bval}.
  - On mismatch: err pulses for 1 cycle and err_cnt increments, saturating at 255.
  - Both reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mult_drv_pkg holds:
  - state enum type mult_drv_state_t (IDLE..RESP).
  - DATA_W_DEF=8.
  - Button level constants BTN_ON=1'b0, BTN_OFF=1'b1.
- One sub-module: phase_timer.
  - Loadable 8-bit down-counter with a done flag.
  - Instantiated once and reloaded with PULSE_CYC-1 or MULT_LAT-1 on state entry.

Test Plan:
- a=0xFF, b=0xFF, rsp_ready=1 → rsp_prod=0x0001 exactly 27 cycles after accept; ClearA_LoadB low 2 cycles with S=0xFF; Run low 2 cycles.
- a=0x07, b=0x03 → rsp_prod=0x0015; a=0x80, b=0x7F → rsp_prod=0xC080; a=0x5A, b=0x00 → 0x0000.
- rsp_ready=0 for 10 cycles after rsp_valid → rsp_valid and rsp_prod held; req_ready=0 throughout; accept occurs on the cycle rsp_ready rises.
- Change req_a/req_b every cycle after accept → product matches the latched pair; second req_valid during busy is not accepted until IDLE.
- Assert Reset during WAIT (cycle 10) → same-cycle async: Run=1, ClearA_LoadB=1, S=0, rsp_valid=0, req_ready=1; next request completes normally.
- With MULT_BUTTON_DRIVER_CHECK_EN: model forces Bval=0x02 for 0xFF*0xFF → err pulses 1 cycle, err_cnt=1; correct run leaves err_cnt unchanged.
